// File: rtl/sobel_window_stream_if.sv
// Stream bundle for the Sobel window generator: input pixel columns and output 3x3 windows.
// The master side feeds columns and consumes windows, and the slave side is the window generator.
interface sobel_window_stream_if #(
  parameter int DW = 8
);
  logic [DW-1:0] col_top_i;
  logic [DW-1:0] col_mid_i;
  logic [DW-1:0] col_bot_i;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] w0_o;
  logic [DW-1:0] w1_o;
  logic [DW-1:0] w2_o;
  logic [DW-1:0] w3_o;
  logic [DW-1:0] w4_o;
  logic [DW-1:0] w5_o;
  logic [DW-1:0] w6_o;
  logic [DW-1:0] w7_o;
  logic [DW-1:0] w8_o;
  logic          out_valid;
  logic          out_ready;
  logic          out_sof;
  logic          out_eol;
  logic          out_eof;

  modport master (
    output col_top_i, col_mid_i, col_bot_i, in_valid, out_ready,
    input  in_ready, w0_o, w1_o, w2_o, w3_o, w4_o, w5_o, w6_o, w7_o, w8_o,
    input  out_valid, out_sof, out_eol, out_eof
  );

  modport slave (
    input  col_top_i, col_mid_i, col_bot_i, in_valid, out_ready,
    output in_ready, w0_o, w1_o, w2_o, w3_o, w4_o, w5_o, w6_o, w7_o, w8_o,
    output out_valid, out_sof, out_eol, out_eof
  );
endinterface

// File: rtl/sobel_window_stream.sv
// 3x3 window generator for the Sobel datapath: one column in per transfer, one registered,
// border-masked window out per image pixel, with valid/ready on both sides and frame markers.
module sobel_window_stream #(
  parameter int DW          = 8,
  parameter int COLS        = 640,
  parameter int ROWS        = 480,
  parameter int BORDER_MODE = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  sobel_window_stream_if.slave bus
);
  localparam int COL_W = $clog2(COLS);
  localparam int ROW_W = $clog2(ROWS);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);
  localparam logic [COL_W-1:0] COL_PEN  = COL_W'(COLS - 2);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);

  typedef enum logic [1:0] {PRIME, RUN, FLUSH} state_t;

  state_t            state_reg, state_next;
  logic [COL_W-1:0]  col_reg, col_next;
  logic [ROW_W-1:0]  row_reg, row_next;
  logic              in_ready, can_load, load, accept;
  logic              at_top, at_bot, at_left, at_right;

  // Two stored columns per row; the incoming column completes the window.
  logic [DW-1:0]     sr_reg   [3][2];
  logic [DW-1:0]     col_in   [3];
  logic [DW-1:0]     raw      [3][3];
  logic [DW-1:0]     tap_next [9];
  logic [DW-1:0]     tap_reg  [9];
  logic              out_valid_reg, sof_reg, eol_reg, eof_reg;

  assign col_in[0] = bus.col_top_i;
  assign col_in[1] = bus.col_mid_i;
  assign col_in[2] = bus.col_bot_i;

  assign can_load = !out_valid_reg || bus.out_ready;
  assign accept   = bus.in_valid && in_ready;

  always_comb begin
    state_next = state_reg;
    in_ready   = 1'b0;
    load       = 1'b0;
    col_next   = col_reg;
    row_next   = row_reg;
    case (state_reg)
      PRIME: begin
        in_ready = 1'b1;
        if (bus.in_valid) state_next = RUN;
      end
      RUN: begin
        in_ready = can_load;
        if (bus.in_valid && can_load) begin
          load     = 1'b1;
          col_next = col_reg + COL_W'(1);
          if (col_reg == COL_PEN) state_next = FLUSH;
        end
      end
      FLUSH: begin
        if (can_load) begin
          load       = 1'b1;
          col_next   = '0;
          row_next   = (row_reg == ROW_LAST) ? '0 : row_reg + ROW_W'(1);
          state_next = PRIME;
        end
      end
      default: state_next = PRIME;
    endcase
  end

  assign at_top   = (row_reg == '0);
  assign at_bot   = (row_reg == ROW_LAST);
  assign at_left  = (col_reg == '0);
  assign at_right = (col_reg == COL_LAST);

  // During FLUSH the right column comes from the input bus but is always masked.
  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_raw
      assign raw[gi][0] = sr_reg[gi][0];
      assign raw[gi][1] = sr_reg[gi][1];
      assign raw[gi][2] = col_in[gi];
    end

    for (gi = 0; gi < 9; gi++) begin : g_tap
      localparam int R = gi / 3;
      localparam int C = gi % 3;
      logic row_mask, col_mask;
      assign row_mask = (R == 0 && at_top) || (R == 2 && at_bot);
      assign col_mask = (C == 0 && at_left) || (C == 2 && at_right);
      if (BORDER_MODE == 0) begin : g_zero
        assign tap_next[gi] = (row_mask || col_mask) ? '0 : raw[R][C];
      end else begin : g_rep
        assign tap_next[gi] = (row_mask && col_mask) ? raw[1][1] :
                              row_mask               ? raw[1][C] :
                              col_mask               ? raw[R][1] : raw[R][C];
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= PRIME;
      col_reg       <= '0;
      row_reg       <= '0;
      out_valid_reg <= 1'b0;
      sof_reg       <= 1'b0;
      eol_reg       <= 1'b0;
      eof_reg       <= 1'b0;
      for (int i = 0; i < 3; i++) begin
        sr_reg[i][0] <= '0;
        sr_reg[i][1] <= '0;
      end
      for (int i = 0; i < 9; i++) tap_reg[i] <= '0;
    end else begin
      state_reg <= state_next;
      col_reg   <= col_next;
      row_reg   <= row_next;
      if (accept) begin
        for (int i = 0; i < 3; i++) begin
          sr_reg[i][0] <= sr_reg[i][1];
          sr_reg[i][1] <= col_in[i];
        end
      end
      if (load) begin
        out_valid_reg <= 1'b1;
        sof_reg       <= at_top && at_left;
        eol_reg       <= at_right;
        eof_reg       <= at_bot && at_right;
        for (int i = 0; i < 9; i++) tap_reg[i] <= tap_next[i];
      end else if (bus.out_ready) begin
        out_valid_reg <= 1'b0;
      end
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_reg;
  assign bus.out_sof   = sof_reg;
  assign bus.out_eol   = eol_reg;
  assign bus.out_eof   = eof_reg;
  assign bus.w0_o      = tap_reg[0];
  assign bus.w1_o      = tap_reg[1];
  assign bus.w2_o      = tap_reg[2];
  assign bus.w3_o      = tap_reg[3];
  assign bus.w4_o      = tap_reg[4];
  assign bus.w5_o      = tap_reg[5];
  assign bus.w6_o      = tap_reg[6];
  assign bus.w7_o      = tap_reg[7];
  assign bus.w8_o      = tap_reg[8];
endmodule
